// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-style floating-point multiplier with valid/ready handshake.
// Define FP_MULT_ROUND_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 1;
  localparam int PW     = 2 * MW;
  localparam int EW     = EXP_W + 2;
  localparam int STAGES = 3;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam logic [EW-1:0] BIAS_X = EW'(BIAS);
  localparam logic [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic nan;
    logic inv;
    logic inf;
    logic zero;
  } cls_t;

  typedef struct packed {
    logic             sign;
    cls_t             cls;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MW-1:0]    ma;
    logic [MW-1:0]    mb;
  } s1_t;

  typedef struct packed {
    logic          sign;
    cls_t          cls;
    logic [EW-1:0] exp;
    logic [PW-1:0] prod;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            advance;
  s1_t             s1, s1_d;
  s2_t             s2, s2_d;
  logic [W-1:0]    res_d;
  logic [3:0]      flg_d;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  // S1: unpack and classify; denormal inputs are flushed to zero
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inf_zero;

  always_comb begin
    ea       = a[W-2 -: EXP_W];
    eb       = b[W-2 -: EXP_W];
    fa       = a[MAN_W-1:0];
    fb       = b[MAN_W-1:0];
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (&ea) && (fa == '0);
    b_inf    = (&eb) && (fb == '0);
    a_nan    = (&ea) && (fa != '0);
    b_nan    = (&eb) && (fb != '0);
    inf_zero = (a_inf && b_zero) || (b_inf && a_zero);
    s1_d          = '0;
    s1_d.sign     = a[W-1] ^ b[W-1];
    s1_d.cls.nan  = a_nan || b_nan || inf_zero;
    s1_d.cls.inv  = inf_zero && !a_nan && !b_nan;
    s1_d.cls.inf  = a_inf || b_inf;
    s1_d.cls.zero = a_zero || b_zero;
    s1_d.ea       = ea;
    s1_d.eb       = eb;
    s1_d.ma       = {1'b1, fa};
    s1_d.mb       = {1'b1, fb};
  end

  // S2: full-width mantissa product; exponent kept as EW-bit two's complement
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1.sign;
    s2_d.cls  = s1.cls;
    s2_d.exp  = {2'b00, s1.ea} + {2'b00, s1.eb} - BIAS_X;
    s2_d.prod = PW'(s1.ma) * PW'(s1.mb);
  end

  // S3: normalise, round, range check, pack
  logic [PW-2:0]    norm;
  logic [EW-1:0]    e_n, e_f;
  logic [MAN_W-1:0] frac_t, frac_f;
  logic [MAN_W+1:0] mant_r;
  logic             guard, rnd, sticky, round_up, inexact, ovf, unf;

  always_comb begin
    norm   = s2.prod[PW-1] ? s2.prod[PW-2:0] : {s2.prod[PW-3:0], 1'b0};
    e_n    = s2.exp + EW'(s2.prod[PW-1]);
    frac_t = norm[PW-2 -: MAN_W];
    guard  = norm[PW-2-MAN_W];
    rnd    = norm[PW-3-MAN_W];
    sticky = |norm[PW-4-MAN_W:0];
    inexact = guard || rnd || sticky;
`ifdef FP_MULT_ROUND_EN
    round_up = guard && (rnd || sticky || frac_t[0]);
`else
    round_up = 1'b0;
`endif
    mant_r = {2'b01, frac_t} + (MAN_W+2)'(round_up);
    // A carry out of the mantissa leaves 10.000..., so the fraction is the shifted value
    e_f    = e_n + EW'(mant_r[MAN_W+1]);
    frac_f = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    ovf    = !e_f[EW-1] && (e_f >= EMAX);
    unf    = e_f[EW-1] || (e_f == '0);

    res_d = {s2.sign, e_f[EXP_W-1:0], frac_f};
    flg_d = {3'b000, inexact};
    if (s2.cls.nan) begin
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flg_d = {s2.cls.inv, 3'b000};
    end else if (s2.cls.inf) begin
      res_d = {s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d = 4'b0000;
    end else if (s2.cls.zero) begin
      res_d = {s2.sign, {(W-1){1'b0}}};
      flg_d = 4'b0000;
    end else if (ovf) begin
      res_d = {s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d = 4'b0101;
    end else if (unf) begin
      res_d = {s2.sign, {(W-1){1'b0}}};
      flg_d = 4'b0011;
    end
  end

  // Every stage, output included, holds while the result is back-pressured
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      result   <= '0;
      flags    <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1       <= s1_d;
      s2       <= s2_d;
      result   <= res_d;
      flags    <= flg_d;
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed-vector bench for fp_mult_pipe (single precision defaults).
module tb_fp_mult_pipe;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;
  int total = 0, bad = 0;

  fp_mult_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated operation; latency counted in cycles after the accepting edge
  task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] er, input logic [3:0] ef);
    int lat;
    @(negedge clk);
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk($sformatf("%s.rdy", tag), 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s.lat", tag), 32'(lat), 32'd3);
    chk($sformatf("%s.res", tag), result, er);
    chk($sformatf("%s.flg", tag), 32'(flags), 32'(ef));
  endtask

  logic [31:0] sa [5], sb [5], sr [5];

  initial begin
    int nin, nout, extra;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    sa = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    sb = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    sr = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.vld", 32'(out_valid), 32'd0);
    chk("rst.res", result, 32'd0);
    chk("rst.flg", 32'(flags), 32'd0);
    chk("rst.rdy", 32'(in_ready), 32'd1);

    run_op("basic",   32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    run_op("sign",    32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000);
`ifdef FP_MULT_ROUND_EN
    run_op("rne",     32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001);
    run_op("carry",   32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001);
    run_op("carryov", 32'h7F7FFFFE, 32'h3F800001, 32'h7F800000, 4'b0101);
`else
    run_op("rne",     32'h3FC00001, 32'h3FC00001, 32'h40100001, 4'b0001);
    run_op("carry",   32'h3FFFFFFE, 32'h3F800001, 32'h3FFFFFFF, 4'b0001);
    run_op("carryov", 32'h7F7FFFFE, 32'h3F800001, 32'h7F7FFFFF, 4'b0001);
`endif
    run_op("infzero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_op("nan",     32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
    run_op("ovf",     32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    run_op("unf",     32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
    run_op("minnorm", 32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000);
    run_op("maxexp",  32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000);
    run_op("denorm",  32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);
    run_op("nzero",   32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
    run_op("inffin",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    run_op("infinf",  32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000);

    // Back-to-back stream with out_ready dropped for cycles 4-6
    nin = 0; nout = 0;
    for (int cyc = 1; cyc <= 40 && nout < 5; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (nin < 5);
      if (nin < 5) begin
        a = sa[nin]; b = sb[nin];
      end
      #1;
      if (out_valid && !out_ready) begin
        chk("stall.rdy", 32'(in_ready), 32'd0);
        chk("stall.hold", result, sr[nout]);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stall.res%0d", nout), result, sr[nout]);
        chk($sformatf("stall.flg%0d", nout), 32'(flags), 32'd0);
        nout++;
      end
      if (in_valid && in_ready) nin++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall.cnt", 32'(nout), 32'd5);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stall.extra", 32'(extra), 32'd0);

    // Reset with two operations in flight and an input presented during reset
    @(negedge clk);
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'h40000000;
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000;
    @(negedge clk);
    a = 32'h40400000; rst = 1'b1;
    @(negedge clk);
    chk("mrst.vld", 32'(out_valid), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("mrst.stale", 32'(extra), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
